// File: rtl/rf_sb_bypass.sv
// Register file with per-register pending bits for decode-stage stalls.
// Reads are combinational; a write in flight can be forwarded to readers.
module rf_sb_bypass #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rdaddr,
    output logic [NRD*DW-1:0] rddata,
    output logic [NRD-1:0]    rdbusy,
    input  logic [AW-1:0]     wraddr,
    input  logic [DW-1:0]     wrdata,
    input  logic              wren,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic              flush
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0]   mem_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            weff;
    logic            sbeff;

    assign weff  = wren   && ((wraddr  != '0) || (ZERO_REG == 0));
    assign sbeff = sb_set && ((sb_addr != '0) || (ZERO_REG == 0));

    // flush beats a new pending mark, which beats the retiring write
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREG; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (sbeff && (sb_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (weff && (wraddr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else if (weff) begin
            mem_q[wraddr] <= wrdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        logic          zero;

        assign a    = rdaddr[i*AW +: AW];
        assign hit  = (BYPASS != 0) && weff && (wraddr == a);
        assign zero = (ZERO_REG != 0) && (a == '0);

        always_comb begin
            rddata[i*DW +: DW] = mem_q[a];
            rdbusy[i]          = busy_q[a];
            if (zero) begin
                rddata[i*DW +: DW] = '0;
                rdbusy[i]          = 1'b0;
            end else if (hit) begin
                rddata[i*DW +: DW] = wrdata;
                rdbusy[i]          = 1'b0;
            end
        end
    end

endmodule

// File: doc/rf_sb_bypass.md
Name: rf_sb_bypass

Overview:
Parametrised successor to the pipeline's general-purpose register file. It adds a configurable number of read ports, configurable data width and register count, and same-cycle write-to-read bypass. It also carries a per-register pending (scoreboard) bit so the decode stage can stall on registers awaiting long-latency results (loads, multiply/divide). It sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
DW, 32, data width in bits
AW, 5, address width; register count = 2**AW
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rdaddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
rddata  out  NRD*DW  read data; port i occupies bits [i*DW +: DW]
rdbusy  out  NRD  port i register has a pending result (stall request)
wraddr  in  AW  write address
wrdata  in  DW  write data
wren  in  1  write enable
sb_set  in  1  mark register sb_addr pending
sb_addr  in  AW  register to mark pending
flush  in  1  clear all pending bits (pipeline flush)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: asserting rst_n low immediately clears all 2**AW data registers to 0 and all busy bits to 0, with no clock needed.
  - Consequence: rddata reads 0 and rdbusy reads 0 on every port while in reset.
  - Release: state holds until the first rising edge after rst_n deasserts.
- Reads: combinational, zero latency, all NRD ports independent.
  - Any ports may address the same register.
- Register-0 handling, ZERO_REG=1:
  - Reads of register 0 return 0.
  - rdbusy for register 0 is 0.
  - Writes and sb_set targeting register 0 are ignored.
- Write-qualification term (weff): weff = wren && (wraddr != 0 || ZERO_REG == 0).
- Bypass, BYPASS=1, per port i:
  - Condition: weff && wraddr == rdaddr_i.
  - Data: rddata_i = wrdata in that same cycle.
  - Busy: rdbusy_i = 0, because the result is arriving now.
- BYPASS=0, per port i:
  - rddata_i is the stored value.
  - rdbusy_i is the stored busy bit, even when a write to that address is present in the same cycle.
- Write: on a rising edge with weff, regfile[wraddr] <= wrdata. The value is visible through storage from the next cycle.
- Scoreboard update at each rising edge, per register r, in this priority order:
  1. flush = 1: busy[r] <= 0 for all r. Flush wins over sb_set and writes in the same cycle.
  2. sb_set && sb_addr == r and the sb_set is qualified (sb_addr != 0 or ZERO_REG = 0): busy[r] <= 1. Set wins over a simultaneous write to r, because the write retires the older op and the new op is still pending.
  3. weff && wraddr == r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- Flush scope: flush does not alter register data, and a write in a flush cycle still updates data.
- rdbusy output: rdbusy_i = busy[rdaddr_i], masked by the bypass rule above and by the register-0 rule.
- No registered outputs: all outputs are combinational functions of the state and the current inputs.
- Out-of-range addresses: cannot occur, because the depth is exactly 2**AW.
- Reset mid-operation: all pending bits are lost. The pipeline is reset simultaneously, so this is intended.

Test Plan:
- Reset and zero register:
  - Stimulus: assert rst_n low mid-cycle after writing r5=0x1234.
  - Required: immediately rddata(r5)=0 and rdbusy=0 with no clock edge.
  - Stimulus: after release, write r0=0xFFFF_FFFF.
  - Required: reading r0 returns 0 and rdbusy(r0)=0, under default parameters.
- Basic write/read all ports, NRD=4:
  - Stimulus: write r1=0xA5A5_0001 through r4=0xA5A5_0004 on successive cycles, then read r1..r4 on ports 0..3 simultaneously.
  - Required: each port returns its own value, and two ports addressing r3 both return 0xA5A5_0003.
- Bypass:
  - Stimulus: with r7=0x11, in the same cycle present wren=1, wraddr=7, wrdata=0x22 and rdaddr0=7.
  - Required: BYPASS=1 gives rddata0=0x22; BYPASS=0 gives 0x11.
  - Required in both builds: the next cycle reads 0x22.
- Scoreboard life cycle:
  - Stimulus: sb_set on r9, then read r9 for three cycles, then write r9=0x99.
  - Required: rdbusy=1 during the three wait cycles; rdbusy=0 in the write cycle (BYPASS=1); rdbusy=0 afterwards; data reads 0x99.
- Simultaneous events:
  - Stimulus: sb_set r9 together with a write to r9.
  - Required: r9 busy next cycle, and data updated.
  - Stimulus: sb_set r10 together with flush.
  - Required: r10 not busy next cycle.
  - Stimulus: flush together with a write to r11=0x5.
  - Required: r11 reads 0x5, and every rdbusy=0.
- Parameter sweep:
  - Stimulus: DW=16, AW=3, NRD=1, ZERO_REG=0, then write r0=0xBEEF and sb_set r0.
  - Required: r0 reads 0xBEEF and rdbusy=1.
  - Stimulus: write r7=0x7777.
  - Required: the value reads back correctly, confirming no aliasing across the 8 entries.
